// File: rtl/maxpool2x2.sv
// rtl/maxpool2x2.sv - non-overlapping 2x2 signed max-pooling stage
// Reads four elements per window from the upstream buffer, writes one maximum per 5 cycles.
module maxpool2x2 #(
  parameter int DATA_WIDTH    = 32,
  parameter int IN_W          = 8,
  parameter int IN_H          = 8,
  parameter int ADR_IN_WIDTH  = 6,
  parameter int ADR_OUT_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     axisif_in_start,
  output logic                     axisif_out_done,
  output logic [ADR_IN_WIDTH-1:0]  out_adrIn,
  input  logic [DATA_WIDTH-1:0]    in_dataIn,
  output logic [ADR_OUT_WIDTH-1:0] out_adrOut,
  output logic [DATA_WIDTH-1:0]    out_dataOut,
  output logic                     out_wr
);

  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;
  localparam logic [ADR_IN_WIDTH-1:0] IN_W_A   = ADR_IN_WIDTH'(IN_W);
  localparam logic [ADR_IN_WIDTH-1:0] OUT_W_A  = ADR_IN_WIDTH'(OUT_W);
  localparam logic [ADR_IN_WIDTH-1:0] OX_LAST  = ADR_IN_WIDTH'(OUT_W - 1);
  localparam logic [ADR_IN_WIDTH-1:0] OY_LAST  = ADR_IN_WIDTH'(OUT_H - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;

  state_t                   state, state_nxt;
  logic [ADR_IN_WIDTH-1:0]  ox, ox_nxt;
  logic [ADR_IN_WIDTH-1:0]  oy, oy_nxt;
  logic [1:0]               k, k_nxt;
  logic signed [DATA_WIDTH-1:0] max_q, max_nxt;
  logic [ADR_IN_WIDTH-1:0]  row, col;
  logic                     last_win;

  // k[1] selects the window row, k[0] the window column
  assign row        = (oy << 1) | {{(ADR_IN_WIDTH-1){1'b0}}, k[1]};
  assign col        = (ox << 1) | {{(ADR_IN_WIDTH-1){1'b0}}, k[0]};
  assign out_adrIn  = row * IN_W_A + col;
  assign out_adrOut = ADR_OUT_WIDTH'(oy * OUT_W_A + ox);
  assign out_dataOut = max_q;
  assign last_win   = (ox == OX_LAST) && (oy == OY_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ox    <= '0;
      oy    <= '0;
      k     <= '0;
      max_q <= '0;
    end else begin
      state <= state_nxt;
      ox    <= ox_nxt;
      oy    <= oy_nxt;
      k     <= k_nxt;
      max_q <= max_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    ox_nxt          = ox;
    oy_nxt          = oy;
    k_nxt           = k;
    max_nxt         = max_q;
    axisif_out_done = 1'b0;
    out_wr          = 1'b0;
    case (state)
      IDLE: begin
        axisif_out_done = 1'b1;
        ox_nxt = '0;
        oy_nxt = '0;
        k_nxt  = '0;
        if (axisif_in_start) state_nxt = LOAD;
      end
      LOAD: begin
        if (k == 2'd0) begin
          max_nxt = $signed(in_dataIn);
        end else if ($signed(in_dataIn) > max_q) begin
          max_nxt = $signed(in_dataIn);
        end
        k_nxt = k + 2'd1;
        if (k == 2'd3) state_nxt = WRITE;
      end
      WRITE: begin
        out_wr = 1'b1;
        if (last_win) begin
          ox_nxt    = '0;
          oy_nxt    = '0;
          state_nxt = IDLE;
        end else begin
          state_nxt = LOAD;
          if (ox == OX_LAST) begin
            ox_nxt = '0;
            oy_nxt = oy + 1'b1;
          end else begin
            ox_nxt = ox + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_maxpool2x2.sv
// tb/tb_maxpool2x2.sv - directed self-checking bench for maxpool2x2
// Drives a 4x4 instance and a default 8x8 instance sharing clock and reset.
module tb_maxpool2x2;

  logic clk;
  logic rst_n;

  logic        start4, done4, wr4;
  logic [3:0]  adr_in4;
  logic [1:0]  adr_out4;
  logic [31:0] data_in4, data_out4;
  logic [31:0] mem4 [16];

  logic        start8, done8, wr8;
  logic [5:0]  adr_in8;
  logic [3:0]  adr_out8;
  logic [31:0] data_in8, data_out8;
  logic [31:0] mem8 [64];

  int n_checks;
  int n_fail;

  int          wr_cnt;
  logic [3:0]  wr_adr [64];
  logic [31:0] wr_dat [64];
  int          wr_cyc [64];
  int          done_first;
  int          done_cnt;

  assign data_in4 = mem4[adr_in4];
  assign data_in8 = mem8[adr_in8];

  maxpool2x2 #(.DATA_WIDTH(32), .IN_W(4), .IN_H(4), .ADR_IN_WIDTH(4), .ADR_OUT_WIDTH(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .axisif_in_start(start4), .axisif_out_done(done4),
    .out_adrIn(adr_in4), .in_dataIn(data_in4), .out_adrOut(adr_out4),
    .out_dataOut(data_out4), .out_wr(wr4)
  );

  maxpool2x2 dut8 (
    .clk(clk), .rst_n(rst_n), .axisif_in_start(start8), .axisif_out_done(done8),
    .out_adrIn(adr_in8), .in_dataIn(data_in8), .out_adrOut(adr_out8),
    .out_dataOut(data_out8), .out_wr(wr8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pooled value of window j for the descending 8x8 ramp: its top-left element
  function automatic logic [31:0] exp8(input int j);
    return 32'(63 - ((j / 4) * 16 + (j % 4) * 2));
  endfunction

  // records write traffic of dut8 for cycles 1..ncyc; start8 drops at rel_cyc
  task automatic collect8(input int ncyc, input int rel_cyc, input int done_lim);
    wr_cnt = 0; done_first = 0; done_cnt = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == rel_cyc) start8 = 1'b0;
      if (wr8 === 1'b1 && wr_cnt < 64) begin
        wr_adr[wr_cnt] = adr_out8;
        wr_dat[wr_cnt] = data_out8;
        wr_cyc[wr_cnt] = c;
        wr_cnt++;
      end
      if (done8 === 1'b1) begin
        if (done_first == 0) done_first = c;
        if (c <= done_lim) done_cnt++;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start4 = 1'b0; start8 = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({done8, wr8, adr_in8, adr_out8, data_out8} !== {1'b1, 1'b0, 6'd0, 4'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_dut8: got done=%0b wr=%0b adrIn=%0d adrOut=%0d data=%0h expected 1 0 0 0 0",
               done8, wr8, adr_in8, adr_out8, data_out8);
    end
    n_checks++;
    if ({done4, wr4, adr_in4, adr_out4, data_out4} !== {1'b1, 1'b0, 4'd0, 2'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_dut4: got done=%0b wr=%0b adrIn=%0d adrOut=%0d data=%0h expected 1 0 0 0 0",
               done4, wr4, adr_in4, adr_out4, data_out4);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if ({done8, wr8, adr_out8, data_out8} !== {1'b1, 1'b0, 4'd0, 32'd0} ||
          {done4, wr4, adr_out4, data_out4} !== {1'b1, 1'b0, 2'd0, 32'd0}) begin
        n_fail++;
        $display("FAIL idle_after_reset cycle %0d: got done8=%0b wr8=%0b done4=%0b wr4=%0b data8=%0h expected 1 0 1 0 0",
                 c, done8, wr8, done4, wr4, data_out8);
      end
    end
  endtask

  task automatic test_ramp_4x4;
    int exp_d [4];
    int exp_rd [4];
    logic exp_wr;
    exp_d  = '{5, 7, 13, 15};
    exp_rd = '{0, 1, 4, 5};
    for (int i = 0; i < 16; i++) mem4[i] = 32'(i);
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int c = 1; c <= 25; c++) begin
      if (c <= 4) begin
        n_checks++;
        if (adr_in4 !== 4'(exp_rd[c-1])) begin
          n_fail++;
          $display("FAIL ramp4_read_adr cycle %0d: got %0d expected %0d", c, adr_in4, exp_rd[c-1]);
        end
      end
      exp_wr = (c % 5 == 0) && (c <= 20);
      n_checks++;
      if (wr4 !== exp_wr) begin
        n_fail++;
        $display("FAIL ramp4_wr cycle %0d: got %0b expected %0b", c, wr4, exp_wr);
      end
      if (exp_wr) begin
        n_checks++;
        if (adr_out4 !== 2'(c / 5 - 1) || data_out4 !== 32'(exp_d[c/5-1])) begin
          n_fail++;
          $display("FAIL ramp4_write cycle %0d: got (%0d,%0d) expected (%0d,%0d)",
                   c, adr_out4, data_out4, c / 5 - 1, exp_d[c/5-1]);
        end
      end
      n_checks++;
      if (done4 !== (c >= 21)) begin
        n_fail++;
        $display("FAIL ramp4_done cycle %0d: got %0b expected %0b", c, done4, c >= 21);
      end
      @(negedge clk);
    end
  endtask

  task automatic run_signed4(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v4,
                             input logic [31:0] v5, input logic [31:0] expv, input string name);
    for (int i = 0; i < 16; i++) mem4[i] = 32'd0;
    mem4[0] = v0; mem4[1] = v1; mem4[4] = v4; mem4[5] = v5;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (wr4 !== 1'b1 || adr_out4 !== 2'd0 || data_out4 !== expv) begin
      n_fail++;
      $display("FAIL %s: got wr=%0b (%0d,%0h) expected wr=1 (0,%0h)", name, wr4, adr_out4, data_out4, expv);
    end
    for (int c = 0; c < 30 && done4 !== 1'b1; c++) @(negedge clk);
    n_checks++;
    if (done4 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_done: got %0b expected 1 within 30 cycles", name, done4);
    end
  endtask

  task automatic test_signed;
    run_signed4(-32'sd5, -32'sd3, -32'sd8, -32'sd7, -32'sd3, "signed_mixed");
    run_signed4(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, "signed_min");
  endtask

  task automatic check_full_run8(input string name, input int base, input int cyc_off);
    for (int j = 0; j < 16; j++) begin
      n_checks++;
      if (wr_adr[base+j] !== 4'(j) || wr_dat[base+j] !== exp8(j) || wr_cyc[base+j] != cyc_off + 5 * (j + 1)) begin
        n_fail++;
        $display("FAIL %s write %0d: got (%0d,%0d)@%0d expected (%0d,%0d)@%0d", name, j,
                 wr_adr[base+j], wr_dat[base+j], wr_cyc[base+j], j, exp8(j), cyc_off + 5 * (j + 1));
      end
    end
  endtask

  task automatic test_ramp_8x8;
    for (int i = 0; i < 64; i++) mem8[i] = 32'(63 - i);
    @(negedge clk); start8 = 1'b1;
    collect8(90, 1, 90);
    n_checks++;
    if (wr_cnt != 16) begin
      n_fail++;
      $display("FAIL ramp8_wr_count: got %0d expected 16", wr_cnt);
    end
    check_full_run8("ramp8", 0, 0);
    n_checks++;
    if (done_first != 81 || done_cnt != 10) begin
      n_fail++;
      $display("FAIL ramp8_done: got first=%0d count=%0d expected first=81 count=10", done_first, done_cnt);
    end
  endtask

  task automatic test_robust;
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
    for (int c = 1; c < 12; c++) begin
      if (c == 7) start8 = 1'b1;
      if (c == 8) start8 = 1'b0;
      if (c == 5 || c == 10) begin
        n_checks++;
        if (wr8 !== 1'b1 || adr_out8 !== 4'(c / 5 - 1) || data_out8 !== exp8(c / 5 - 1)) begin
          n_fail++;
          $display("FAIL robust_write cycle %0d: got wr=%0b (%0d,%0d) expected wr=1 (%0d,%0d)",
                   c, wr8, adr_out8, data_out8, c / 5 - 1, exp8(c / 5 - 1));
        end
      end
      if (c == 8) begin
        n_checks++;
        if (done8 !== 1'b0) begin
          n_fail++;
          $display("FAIL robust_ignore_start: got done=%0b expected 0", done8);
        end
      end
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({done8, wr8, adr_in8, adr_out8, data_out8} !== {1'b1, 1'b0, 6'd0, 4'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL robust_async_reset: got done=%0b wr=%0b adrIn=%0d adrOut=%0d data=%0h expected 1 0 0 0 0",
               done8, wr8, adr_in8, adr_out8, data_out8);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (wr8 !== 1'b0 || done8 !== 1'b1) begin
        n_fail++;
        $display("FAIL robust_post_reset cycle %0d: got wr=%0b done=%0b expected 0 1", c, wr8, done8);
      end
    end
    @(negedge clk); start8 = 1'b1;
    collect8(85, 1, 85);
    n_checks++;
    if (wr_cnt != 16 || done_first != 81) begin
      n_fail++;
      $display("FAIL robust_rerun: got writes=%0d done_first=%0d expected 16 81", wr_cnt, done_first);
    end
    check_full_run8("robust_rerun", 0, 0);
  endtask

  task automatic test_held_start;
    @(negedge clk); start8 = 1'b1;
    collect8(170, 120, 161);
    n_checks++;
    if (wr_cnt != 32) begin
      n_fail++;
      $display("FAIL held_wr_count: got %0d expected 32", wr_cnt);
    end
    n_checks++;
    if (done_first != 81 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL held_done: got first=%0d count=%0d expected first=81 count=1", done_first, done_cnt);
    end
    check_full_run8("held_run1", 0, 0);
    check_full_run8("held_run2", 16, 81);
    n_checks++;
    if (done8 !== 1'b1) begin
      n_fail++;
      $display("FAIL held_final_idle: got done=%0b expected 1", done8);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) mem4[i] = 32'd0;
    for (int i = 0; i < 64; i++) mem8[i] = 32'd0;
    test_reset();
    test_ramp_4x4();
    test_signed();
    test_ramp_8x8();
    test_robust();
    test_held_start();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/maxpool2x2.md
Name: maxpool2x2

Overview:
Non-overlapping 2x2 max-pooling stage that sits directly downstream of the ReLU stage. It consumes the feature map that the ReLU stage wrote to its output buffer and writes a pooled map of half the width and half the height to the next layer's buffer. It uses the same start/done control interface and the same asynchronous-read input-memory interface as the neighbouring stages. It processes one 2x2 window per 5 clock cycles.

Parameters:
DATA_WIDTH, 32, element width; two's-complement signed.
IN_W, 8, input map width; must be even and >= 2.
IN_H, 8, input map height; must be even and >= 2.
ADR_IN_WIDTH, 6, input address width; must satisfy 2^ADR_IN_WIDTH >= IN_W*IN_H.
ADR_OUT_WIDTH, 4, output address width; must satisfy 2^ADR_OUT_WIDTH >= (IN_W/2)*(IN_H/2).

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
axisif_in_start  in  1  start request; sampled only in IDLE.
axisif_out_done  out  1  high exactly while in IDLE.
out_adrIn  out  ADR_IN_WIDTH  input buffer read address.
in_dataIn  in  DATA_WIDTH  input buffer read data; combinational, valid in the same cycle as out_adrIn.
out_adrOut  out  ADR_OUT_WIDTH  output buffer write address.
out_dataOut  out  DATA_WIDTH  output buffer write data.
out_wr  out  1  output buffer write strobe; one cycle per pooled element.

Behaviour:
- Reset (asynchronous, active-low rst_n), including mid-operation:
  - State goes to IDLE; counters ox, oy, k and the max register go to 0.
  - Outputs: done=1, wr=0, out_adrIn=0, out_adrOut=0, out_dataOut=0.
  - No partial write is issued.
- Memory layout: row-major. Input address = row*IN_W + col. Output address = oy*(IN_W/2) + ox.
- Counters:
  - k (2 bits): window position. 0=(dy0,dx0), 1=(0,1), 2=(1,0), 3=(1,1).
  - ox: 0..IN_W/2-1.
  - oy: 0..IN_H/2-1.
- out_adrIn is always (2*oy+dy)*IN_W + (2*ox+dx), computed combinationally from the counters.
- out_adrOut is always oy*(IN_W/2)+ox. out_dataOut is always the max register.
- States: IDLE, LOAD, WRITE.
- IDLE:
  - done=1, wr=0.
  - Counters clear to 0 every cycle.
  - axisif_in_start=1 at a clock edge moves the state to LOAD.
- LOAD:
  - done=0, wr=0.
  - On k=0 the max register loads in_dataIn. On k=1..3 it loads the signed maximum of itself and in_dataIn.
  - Ties: either operand may be kept (the value is identical).
  - k increments each cycle. On k=3 the state moves to WRITE and k wraps to 0.
- WRITE:
  - wr=1, done=0. The max register holds its value.
  - At the clock edge the window advances: ox increments; on ox wrap, ox=0 and oy increments.
  - If (ox,oy) was the last window, the state moves to IDLE; otherwise to LOAD.
- Timing (edge 0 = the edge that samples start):
  - Window n occupies LOAD cycles 5n+1..5n+4 and WRITE cycle 5n+5.
  - done rises in cycle 5*N_OUT+1, where N_OUT=(IN_W/2)*(IN_H/2). For the defaults N_OUT=16, so done rises in cycle 81.
- axisif_in_start while not in IDLE is ignored.
- If start is held high through completion, the block spends exactly 1 cycle in IDLE (done=1) and then restarts.
- Comparison is signed across the full DATA_WIDTH with no saturation. Because the input comes from ReLU it is normally >= 0, but negative inputs must still pool correctly.
- There is no output register latency: data and address are stable throughout the WRITE cycle.

Test Plan:
- Reset then idle: hold rst_n=0, then release with start=0 for 10 cycles -> done=1, wr=0, out_adrOut=0, out_dataOut=0 throughout.
- IN_W=IN_H=4, input[i]=i: pulse start -> 4 writes at cycles 5,10,15,20 with (adr,data)=(0,5),(1,7),(2,13),(3,15); done=1 from cycle 21. Check the read addresses for the first window are 0,1,4,5.
- Signed window (4x4, window 0 = {-5,-3,-8,-7}, others 0) -> write (0,-3). All four elements = 0x80000000 -> write 0x80000000.
- Default 8x8, input[i]=63-i -> 16 writes, output j = input at the top-left of window j. Exactly 16 wr pulses; done rises in cycle 81.
- Robustness: pulse start again in cycle 7 -> ignored. Assert rst_n=0 in cycle 12 -> immediate IDLE, no further wr. A following start produces a clean full run from address 0.
- Held start: keep start=1 across completion -> done high for exactly 1 cycle, then a second run with identical outputs.
